instruction_memory_ctrl: RTL and testbench

Parametrised, byte-addressed instruction memory with a valid/ready fetch port and a byte-strobed write port. Fetches return 32 bits starting at any halfword-aligned address, so a 32-bit instruction can follow a compressed one. Read latency is one registered cycle, with a one-entry output stage that absorbs backpressure. Sits between the fetch stage and the program store; writes come from the debug/loader path.

---
 rtl/instruction_memory_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_instruction_memory_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_ctrl.sv
// -----------------------------------------------------------------------------
// instruction_memory_ctrl
//
// Purpose:
//   Byte-addressed instruction memory for the fetch stage. A valid/ready fetch
//   port returns 32 little-endian bits from any halfword-aligned address. A
//   fetch at the top of the array continues from byte 0. Read latency is one
//   registered cycle. A one-entry output stage holds the response under
//   backpressure. A byte-strobed write port serves the debug/loader path.
//   Memory contents are supplied through the write port or the loader.
//
// Optional feature (macro IMEM_LOADER_EN):
//   Adds a streaming loader. While it is busy it owns the write path and
//   blocks fetches.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   fetch_valid/ready/addr    fetch request handshake and byte address
//   resp_valid/ready          response handshake
//   resp_data/addr/fault      instruction word, its address, fault flag
//   wr_en/addr/data/strb      byte-strobed write port
//   load_start/valid/data     (IMEM_LOADER_EN) loader control and data
//   load_busy                 (IMEM_LOADER_EN) loader active
// -----------------------------------------------------------------------------
module instruction_memory_ctrl #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter string       INIT_FILE   = "instruction_mem_temp.mem",
  localparam int unsigned IDX_W      = $clog2(DEPTH_BYTES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [31:0] resp_addr,
  output logic        resp_fault,
`ifdef IMEM_LOADER_EN
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  output logic        load_busy,
`endif
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb
);

  // ---------------------------------------------------------------------------
  // Storage (not reset)
  // ---------------------------------------------------------------------------
  logic [7:0] mem_q [DEPTH_BYTES];

  // ---------------------------------------------------------------------------
  // Optional loader FSM
  // ---------------------------------------------------------------------------
  logic loader_active;

`ifdef IMEM_LOADER_EN
  typedef enum logic {
    IDLE,
    LOAD
  } state_e;

  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(DEPTH_BYTES - 4);

  state_e           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic             busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_start) begin
            state_q <= LOAD;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          // A second load_start aborts. The word offered in the same cycle is
          // not written.
          if (load_start) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (load_valid) begin
            ptr_q <= ptr_q + IDX_W'(4);
            if (ptr_q == LAST_PTR) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign load_busy     = busy_q;
  assign loader_active = (state_q == LOAD);
`else
  assign loader_active = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Write path: the external port, or the loader while it is active
  // ---------------------------------------------------------------------------
  logic             wr_go;
  logic [IDX_W-1:0] wr_base;
  logic [31:0]      wr_word;
  logic [3:0]       wr_be;

  always_comb begin
    wr_go   = wr_en && (wr_addr[31:IDX_W] == '0);
    wr_base = wr_addr[IDX_W-1:0];
    wr_word = wr_data;
    wr_be   = wr_strb;
`ifdef IMEM_LOADER_EN
    if (loader_active) begin
      wr_go   = load_valid && !load_start;
      wr_base = ptr_q;
      wr_word = load_data;
      wr_be   = '1;
    end
`endif
  end

  // Byte lanes wrap modulo DEPTH_BYTES through the IDX_W-bit index sum.
  always_ff @(posedge clk) begin
    if (wr_go) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (wr_be[k]) begin
          mem_q[wr_base + IDX_W'(k)] <= wr_word[8*k +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] rd_idx0, rd_idx1, rd_idx2, rd_idx3;
  logic [31:0]      rd_word;
  logic             fetch_fault;
  logic             accept;

  always_comb begin
    rd_idx0 = fetch_addr[IDX_W-1:0];
    rd_idx1 = rd_idx0 + IDX_W'(1);
    rd_idx2 = rd_idx0 + IDX_W'(2);
    rd_idx3 = rd_idx0 + IDX_W'(3);
    rd_word = {mem_q[rd_idx3], mem_q[rd_idx2], mem_q[rd_idx1], mem_q[rd_idx0]};
  end

  assign fetch_fault = fetch_addr[0] || (fetch_addr[31:IDX_W] != '0);

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q,  resp_data_d;
  logic [31:0] resp_addr_q,  resp_addr_d;
  logic        resp_fault_q, resp_fault_d;

  assign fetch_ready = (!resp_valid_q || resp_ready) && !loader_active;
  assign accept      = fetch_valid && fetch_ready;

  // The stage reads the array directly. Writes commit at the same edge, so a
  // fetch accepted with an overlapping write returns the pre-write bytes.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_addr_d  = resp_addr_q;
    resp_fault_d = resp_fault_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_addr_d  = fetch_addr;
      resp_fault_d = fetch_fault;
      resp_data_d  = fetch_fault ? '0 : rd_word;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_addr_q  <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_addr_q  <= resp_addr_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_addr  = resp_addr_q;
  assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_instruction_memory_ctrl.sv
// -----------------------------------------------------------------------------
// tb_instruction_memory_ctrl
//
// Directed bench for instruction_memory_ctrl (default build, DEPTH_BYTES=1024).
// The memory image is built through the write port, so no init file is used.
// -----------------------------------------------------------------------------
module tb_instruction_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [31:0] fetch_addr = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic [31:0] resp_addr;
  logic        resp_fault;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_strb = '0;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  instruction_memory_ctrl #(
    .DEPTH_BYTES(1024),
    .INIT_FILE  ("")
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready),
    .fetch_addr (fetch_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_addr  (resp_addr),
    .resp_fault (resp_fault),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_strb    (wr_strb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_strb = s;
    tick();
    wr_en   = 1'b0;
    wr_strb = '0;
  endtask

  // Single fetch with resp_ready=1; leaves the response visible.
  task automatic fetch(input logic [31:0] a);
    fetch_valid = 1'b1;
    fetch_addr  = a;
    tick();
    fetch_valid = 1'b0;
  endtask

  initial begin
    // ---------------- reset ----------------
    tick();
    tick();
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_data",  resp_data, 32'd0);
    chk("rst_addr",  resp_addr, 32'd0);
    chk("rst_fault", {31'd0, resp_fault}, 32'd0);
    chk("rst_fready", {31'd0, fetch_ready}, 32'd1);
    rst = 1'b0;
    tick();

    // ---------------- image ----------------
    wr(32'h000, 32'h0000_0013, 4'hF);
    wr(32'h004, 32'hA5A5_0004, 4'hF);
    wr(32'h008, 32'hCAFE_0008, 4'hF);
    wr(32'h010, 32'h0000_0000, 4'hF);
    wr(32'h020, 32'h1234_5678, 4'hF);
    wr(32'h3FC, 32'h4433_2211, 4'hF);

    // ---------------- basic fetch ----------------
    fetch(32'h0);
    chk("f0_valid", {31'd0, resp_valid}, 32'd1);
    chk("f0_data",  resp_data, 32'h0000_0013);
    chk("f0_fault", {31'd0, resp_fault}, 32'd0);
    chk("f0_addr",  resp_addr, 32'h0);
    tick();
    chk("idle_valid", {31'd0, resp_valid}, 32'd0);
    chk("idle_hold",  resp_data, 32'h0000_0013);

    // ---------------- strobed write ----------------
    wr(32'h010, 32'hDEAD_BEEF, 4'b0101);
    fetch(32'h010);
    chk("strb_data", resp_data, 32'h00AD_00EF);

    // ---------------- wrap and faults, back to back ----------------
    fetch_valid = 1'b1;
    fetch_addr  = 32'h3FE;
    tick();
    chk("wrap_data",  resp_data, 32'h0013_4433);
    chk("wrap_fault", {31'd0, resp_fault}, 32'd0);
    fetch_addr = 32'h3;
    tick();
    chk("mis_valid", {31'd0, resp_valid}, 32'd1);
    chk("mis_fault", {31'd0, resp_fault}, 32'd1);
    chk("mis_data",  resp_data, 32'd0);
    chk("mis_addr",  resp_addr, 32'h3);
    fetch_addr = 32'h400;
    tick();
    chk("oor_fault", {31'd0, resp_fault}, 32'd1);
    chk("oor_data",  resp_data, 32'd0);
    fetch_valid = 1'b0;
    tick();

    // ---------------- dropped writes ----------------
    wr(32'h404, 32'hFFFF_FFFF, 4'hF);
    wr(32'h008, 32'hFFFF_FFFF, 4'h0);
    fetch(32'h004);
    chk("oorwr_data", resp_data, 32'hA5A5_0004);
    fetch(32'h008);
    chk("strb0_data", resp_data, 32'hCAFE_0008);
    tick();

    // ---------------- backpressure ----------------
    resp_ready  = 1'b0;
    fetch_valid = 1'b1;
    fetch_addr  = 32'h004;
    tick();
    chk("bp_first", resp_data, 32'hA5A5_0004);
    fetch_addr = 32'h008;
    #1;
    chk("bp_fready", {31'd0, fetch_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid",  {31'd0, resp_valid}, 32'd1);
      chk("bp_data",   resp_data, 32'hA5A5_0004);
      chk("bp_addr",   resp_addr, 32'h004);
      chk("bp_fready", {31'd0, fetch_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_release", {31'd0, fetch_ready}, 32'd1);
    tick();
    fetch_valid = 1'b0;
    chk("bp_next_data", resp_data, 32'hCAFE_0008);
    chk("bp_next_addr", resp_addr, 32'h008);
    tick();
    chk("bp_drain", {31'd0, resp_valid}, 32'd0);

    // ---------------- same-edge write and fetch ----------------
    wr_en       = 1'b1;
    wr_addr     = 32'h020;
    wr_data     = 32'hFFFF_FFFF;
    wr_strb     = 4'hF;
    fetch_valid = 1'b1;
    fetch_addr  = 32'h020;
    tick();
    wr_en       = 1'b0;
    wr_strb     = '0;
    fetch_valid = 1'b0;
    chk("rbw_old", resp_data, 32'h1234_5678);
    fetch(32'h020);
    chk("rbw_new", resp_data, 32'hFFFF_FFFF);

    // ---------------- reset mid-operation ----------------
    resp_ready = 1'b0;
    fetch(32'h000);
    chk("mr_pending", {31'd0, resp_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_valid", {31'd0, resp_valid}, 32'd0);
    chk("mr_data",  resp_data, 32'd0);
    tick();
    rst = 1'b0;
    resp_ready = 1'b1;
    tick();
    fetch(32'h000);
    chk("mr_mem_kept", resp_data, 32'h0000_0013);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
